// File: rtl/submod_rx.sv
// Receiver for the submod output channel: FWFT FIFO with sticky overflow/parity-error flags.
// Optional parity screening is enabled by defining SUBMOD_RX_PARITY_EN.
module submod_rx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    input  logic [WIDTH-1:0]         in_data_i,
    input  logic                     in_par_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         out_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     par_err_o,
    input  logic                     clr_i
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             word_good;
    logic             full, push, pop, ovf_set;

`ifdef SUBMOD_RX_PARITY_EN
    logic par_err_q, par_err_d;
    logic par_set;

    // Even parity over data plus parity bit.
    assign word_good = ~^{in_data_i, in_par_i};
    assign par_set   = in_valid_i && !word_good;
    assign par_err_o = par_err_q;

    always_comb begin
        par_err_d = par_err_q;
        if (par_set) begin
            par_err_d = 1'b1;
        end else if (clr_i) begin
            par_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`else
    logic unused_par;
    assign unused_par = in_par_i;
    assign word_good  = 1'b1;
    assign par_err_o  = 1'b0;
`endif

    assign full    = (count_q == CntFull);
    assign pop     = out_valid_o && out_ready_i;
    assign push    = in_valid_i && word_good && (!full || pop);
    assign ovf_set = in_valid_i && word_good && full && !pop;

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as clr keeps the flag set.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_submod_rx.sv
// Directed self-checking bench for submod_rx (WIDTH=4, DEPTH=4).
module tb_submod_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_par;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [2:0] count;
    logic       overflow;
    logic       par_err;
    logic       clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    submod_rx #(.WIDTH(4), .DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_par_i    (in_par),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .count_o     (count),
        .overflow_o  (overflow),
        .par_err_o   (par_err),
        .clr_i       (clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_par   = ^d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_par = 1'b0;
        out_ready = 1'b0; clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_count", count, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_perr", par_err, 0);

        // Single word in and out.
        push_word(4'hA);
        check_eq("single_valid", out_valid, 1);
        check_eq("single_data", out_data, 4'hA);
        check_eq("single_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("single_pop_count", count, 0);
        check_eq("single_pop_valid", out_valid, 0);

        // Fill and overflow.
        for (int i = 1; i <= 5; i++) push_word(4'(i));
        check_eq("fill_count", count, 4);
        check_eq("fill_ovf", overflow, 1);

        // clr loses to a simultaneous drop, then clears alone.
        clr = 1'b1; in_valid = 1'b1; in_data = 4'h6; in_par = ^4'h6;
        step();
        in_valid = 1'b0;
        check_eq("clr_vs_set_ovf", overflow, 1);
        check_eq("clr_vs_set_count", count, 4);
        step();
        clr = 1'b0;
        check_eq("clr_alone_ovf", overflow, 0);

        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_eq("drain1_valid", out_valid, 1);
            check_eq("drain1_data", out_data, 32'(i));
            step();
        end
        out_ready = 1'b0;
        check_eq("drain1_empty", count, 0);

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) push_word(4'(i));
        check_eq("full2_count", count, 4);
        out_ready = 1'b1;
        push_word(4'h5);
        check_eq("fullpp_count", count, 4);
        check_eq("fullpp_ovf", overflow, 0);
        for (int i = 2; i <= 5; i++) begin
            check_eq("drain2_data", out_data, 32'(i));
            step();
        end
        check_eq("drain2_empty", count, 0);

        // Stream 12 words through, wrapping the pointers several times.
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_data = 4'(k + 1);
            in_par  = ^in_data;
            step();
            check_eq("stream_data", out_data, 32'(k + 1));
            check_eq("stream_count", count, 1);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check_eq("stream_empty", count, 0);
        check_eq("stream_ovf", overflow, 0);

        // Parity screening.
        in_valid = 1'b1; in_data = 4'h3; in_par = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef SUBMOD_RX_PARITY_EN
        check_eq("par_bad_count", count, 0);
        check_eq("par_bad_flag", par_err, 1);
`else
        check_eq("par_bad_count", count, 1);
        check_eq("par_bad_flag", par_err, 0);
`endif
        in_valid = 1'b1; in_data = 4'h3; in_par = 1'b0;
        step();
        in_valid = 1'b0;
`ifdef SUBMOD_RX_PARITY_EN
        check_eq("par_good_count", count, 1);
`else
        check_eq("par_good_count", count, 2);
`endif
        check_eq("par_good_data", out_data, 4'h3);
        check_eq("par_ovf", overflow, 0);
        out_ready = 1'b1; clr = 1'b1;
        step();
        step();
        out_ready = 1'b0; clr = 1'b0;
        check_eq("par_drain_count", count, 0);
        check_eq("par_clr_flag", par_err, 0);

        // Reset mid-stream.
        push_word(4'h7);
        push_word(4'h8);
        push_word(4'h9);
        check_eq("mid_count", count, 3);
        rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; in_par = 1'b0;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check_eq("mid_rst_count", count, 0);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_ovf", overflow, 0);
        check_eq("mid_rst_perr", par_err, 0);
        push_word(4'hB);
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_data", out_data, 4'hB);
        check_eq("post_rst_count", count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/submod_rx.md
# submod_rx

Receiving end of the `submod` output channel. Captures `WIDTH`-bit words presented by a `submod` instance on a valid strobe, buffers them in a small first-word-fall-through FIFO, and hands them to downstream logic over a valid/ready handshake. The producer has no backpressure, so loss is reported through sticky status flags; optional parity checking screens corrupted words.

## Interface
- `WIDTH`, default 4: data word width; must match the producing `submod` instance's `WIDTH`.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  producer strobe; `in_data`/`in_par` are valid this cycle.
- `in_data`  input  WIDTH  producer word.
- `in_par`  input  1  producer even-parity bit; ignored unless `SUBMOD_RX_PARITY_EN`.
- `out_valid`  output  1  FIFO head is valid.
- `out_ready`  input  1  consumer accepts head.
- `out_data`  output  WIDTH  FIFO head word.
- `count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  output  1  sticky; a word was dropped because the FIFO was full.
- `par_err`  output  1  sticky; a word was dropped for bad parity.
- `clr`  input  1  clears `overflow` and `par_err`.

## Operation
- Push condition: `in_valid` and word passes the parity check (always passes without macro) and (not full, or pop in same cycle).
- Pop condition: `out_valid && out_ready`.
- Write pointer and read pointer are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` tracks occupancy: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full (`count == DEPTH`) with simultaneous pop: push accepted, `count` stays DEPTH, no overflow.
- Full without pop and `in_valid` with a good word: word dropped, `overflow` set.
- Empty with simultaneous `in_valid`: no bypass. Word is stored; `out_valid` rises the next cycle.
- `out_valid = (count != 0)`. `out_data` = memory at read pointer, combinational from registered state.
- `out_data` is don't-care while `out_valid` is 0. The bench must not check it.
- Sticky flags: a set event wins over `clr` in the same cycle. Otherwise `clr` drives the flag to 0.
- Reset: pointers 0, `count` 0, `out_valid` 0, `overflow` 0, `par_err` 0. Memory contents are not reset.
- `rst` mid-stream discards all buffered words. Inputs in the reset cycle are ignored.

## Timing
- Push at edge N: word visible on `out_data` with `out_valid` = 1 from edge N (cycle N+1). Latency is 1 cycle.
- Pop at edge N: next entry (if any) presented from edge N. Back-to-back one word per cycle is sustained.
- `overflow`/`par_err` assert one cycle after the offending `in_valid` cycle.
- No combinational path from `in_*` to any output. `out_ready` does not combinationally affect `out_valid`/`out_data`.

## Configuration
- `SUBMOD_RX_PARITY_EN` defined:
  - Word is good iff `^{in_data, in_par} == 0`.
  - A bad word is never pushed, sets `par_err`, and does not count toward `overflow`.
- `SUBMOD_RX_PARITY_EN` undefined:
  - `in_par` is unused; all words are good.
  - `par_err` is tied to 0.

## Test plan
- Reset then single word: `in_valid`=1, `in_data`=4'hA. → Next cycle `out_valid`=1, `out_data`=4'hA, `count`=1. Pop with `out_ready`=1. → `count`=0, `out_valid`=0.
- Fill and overflow (DEPTH=4, `out_ready`=0): push 1,2,3,4,5. → `count`=4, `overflow`=1. Drain yields 1,2,3,4 in order.
- Full with simultaneous push/pop: FIFO holds 1..4; push 5 while popping. → `count` stays 4, `overflow`=0. Drain yields 2,3,4,5. Repeat past pointer wrap (12 words streamed) with no loss.
- `clr` vs set: with `overflow`=1, assert `clr` in the same cycle as a dropped push. → `overflow` stays 1. `clr` alone the next cycle. → `overflow`=0.
- Parity (macro on): push `in_data`=4'h3, `in_par`=1. → Dropped, `par_err`=1, `count` unchanged. Push 4'h3 with `in_par`=0. → Accepted. With the macro off, both words are accepted and `par_err` stays 0.
- Reset mid-operation: `count`=3, assert `rst` with `in_valid`=1. → Next cycle `count`=0, `out_valid`=0, flags 0. The first post-reset push is presented correctly.
